// File: rtl/stream_to_bram_pkg.sv
// Shared definitions for the stream-to-BRAM capture block.
// Holds the capture FSM state encoding, the trigger-mode codes, the register-file
// layout and helpers that turn raw register fields into effective settings.
package stream_to_bram_pkg;

    localparam int REG_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [1:0] TRIG_IMMEDIATE = 2'd0;
    localparam logic [1:0] TRIG_ORBIT     = 2'd1;
    localparam logic [1:0] TRIG_RING      = 2'd2;

    // The first member is the most significant word, so reg0 sits at bits [31:0].
    typedef struct packed {
        logic [REG_W-1:0] status;       // reg3
        logic [REG_W-1:0] ctrl;         // reg2
        logic [REG_W-1:0] capture_len;  // reg1
        logic [REG_W-1:0] trig_mode;    // reg0
    } param_t;

    // A length of zero or one larger than the memory means "fill the whole memory".
    function automatic logic [16:0] effective_len(input logic [15:0] len, input int depth);
        if (len == 16'd0 || 32'(len) > 32'(depth))
            return 17'(depth);
        return {1'b0, len};
    endfunction

    // The reserved mode code behaves like an immediate start.
    function automatic logic [1:0] effective_mode(input logic [1:0] mode);
        return (mode == 2'd3) ? TRIG_IMMEDIATE : mode;
    endfunction

endpackage

// File: rtl/IPIF_parameterDecode.sv
// Generic IPIF register file.
// Holds N_REG writable registers loaded from DEFAULTS on reset. Register i is
// written when WrCE[i] is high and read when RdCE[i] is high; registers whose
// USE_INPUTS bit is set read back parameters_in instead of the stored value,
// so the owner can expose status or masked views.
// Ports: clk, IPIF_Bus2IP_resetn (async, active-low), Bus2IP_Data/RdCE/WrCE in,
// IP2Bus_Data/RdAck/WrAck out, parameters_in (readback), parameters_out (stored).
module IPIF_parameterDecode #(
    parameter int                                     C_S_AXI_DATA_WIDTH = 32,
    parameter int                                     N_REG              = 4,
    parameter logic [N_REG*C_S_AXI_DATA_WIDTH-1:0]    DEFAULTS           = '0,
    parameter logic [N_REG-1:0]                       USE_INPUTS         = '0
) (
    input  logic                                  clk,
    input  logic                                  IPIF_Bus2IP_resetn,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]         IPIF_Bus2IP_Data,
    input  logic [N_REG-1:0]                      IPIF_Bus2IP_RdCE,
    input  logic [N_REG-1:0]                      IPIF_Bus2IP_WrCE,
    output logic [C_S_AXI_DATA_WIDTH-1:0]         IPIF_IP2Bus_Data,
    output logic                                  IPIF_IP2Bus_RdAck,
    output logic                                  IPIF_IP2Bus_WrAck,
    input  logic [N_REG*C_S_AXI_DATA_WIDTH-1:0]   parameters_in,
    output logic [N_REG*C_S_AXI_DATA_WIDTH-1:0]   parameters_out
);

    localparam int W = C_S_AXI_DATA_WIDTH;

    // NOTE: clocked state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge IPIF_Bus2IP_resetn) begin
        if (!IPIF_Bus2IP_resetn) begin
            parameters_out <= DEFAULTS;
        end else begin
            for (int i = 0; i < N_REG; i++) begin
                if (IPIF_Bus2IP_WrCE[i])
                    parameters_out[i*W +: W] <= IPIF_Bus2IP_Data;
            end
        end
    end

    // NOTE: default first so every path assigns the output and no latch is inferred.
    always_comb begin
        IPIF_IP2Bus_Data = '0;
        for (int i = 0; i < N_REG; i++) begin
            if (IPIF_Bus2IP_RdCE[i])
                IPIF_IP2Bus_Data = USE_INPUTS[i] ? parameters_in[i*W +: W]
                                                 : parameters_out[i*W +: W];
        end
    end

    // Single-cycle accesses: acknowledge in the strobe cycle.
    assign IPIF_IP2Bus_RdAck = |IPIF_Bus2IP_RdCE;
    assign IPIF_IP2Bus_WrAck = |IPIF_Bus2IP_WrCE;

endmodule

// File: rtl/stream_to_bram_capture.sv
// Captures a 32-bit AXI stream into a BRAM write port.
// Arming, trigger mode and length come from the IPIF register file; capture
// starts immediately, on a registered orbit-sync pulse, or runs as a ring.
// Ports: clk/aresetn; IPIF slave (register file, reg0..reg3); fc_orbitSync;
// BRAM write port (bram_*), one registered stage after the accept;
// data_stream_* AXI-stream sink, always ready out of reset.
module stream_to_bram_capture
    import stream_to_bram_pkg::*;
#(
    parameter int MEM_DEPTH          = 2048,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int N_REG              = 4
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic                              IPIF_Bus2IP_resetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     IPIF_Bus2IP_Addr,
    input  logic                              IPIF_Bus2IP_RNW,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   IPIF_Bus2IP_BE,
    input  logic                              IPIF_Bus2IP_CS,
    input  logic [N_REG-1:0]                  IPIF_Bus2IP_RdCE,
    input  logic [N_REG-1:0]                  IPIF_Bus2IP_WrCE,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     IPIF_Bus2IP_Data,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     IPIF_IP2Bus_Data,
    output logic                              IPIF_IP2Bus_WrAck,
    output logic                              IPIF_IP2Bus_RdAck,
    output logic                              IPIF_IP2Bus_Error,
    input  logic                              fc_orbitSync,
    output logic                              bram_CLK,
    output logic                              bram_RST,
    output logic                              bram_EN,
    output logic [3:0]                        bram_WE,
    output logic [31:0]                       bram_ADDR,
    output logic [31:0]                       bram_DIN,
    input  logic [31:0]                       data_stream_TDATA,
    input  logic                              data_stream_TVALID,
    output logic                              data_stream_TREADY
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int RW = N_REG * C_S_AXI_DATA_WIDTH;
    localparam param_t DEFAULTS = '{status: '0, ctrl: '0,
                                    capture_len: 32'(MEM_DEPTH), trig_mode: '0};

    param_t          regs;
    param_t          readback;
    logic [RW-1:0]   params_out;

    state_t          state_q, state_d;
    logic            orbit_sync_r, arm_prev;
    logic [1:0]      mode_q;
    logic [16:0]     len_q, ww_q;
    logic [AW-1:0]   widx_q, addr_q;
    logic            done_q, en_q;
    logic [31:0]     din_q;
    logic            arm_edge, abort, accept, trigger, last_word, arm_start, wr_en;

    // Every register reads back through parameters_in so unlisted bits read 0.
    IPIF_parameterDecode #(
        .C_S_AXI_DATA_WIDTH (C_S_AXI_DATA_WIDTH),
        .N_REG              (N_REG),
        .DEFAULTS           (DEFAULTS),
        .USE_INPUTS         ({N_REG{1'b1}})
    ) u_regs (
        .clk                (clk),
        .IPIF_Bus2IP_resetn (IPIF_Bus2IP_resetn),
        .IPIF_Bus2IP_Data   (IPIF_Bus2IP_Data),
        .IPIF_Bus2IP_RdCE   (IPIF_Bus2IP_RdCE),
        .IPIF_Bus2IP_WrCE   (IPIF_Bus2IP_WrCE),
        .IPIF_IP2Bus_Data   (IPIF_IP2Bus_Data),
        .IPIF_IP2Bus_RdAck  (IPIF_IP2Bus_RdAck),
        .IPIF_IP2Bus_WrAck  (IPIF_IP2Bus_WrAck),
        .parameters_in      (readback),
        .parameters_out     (params_out)
    );

    assign regs = param_t'(params_out);

    always_comb begin
        readback             = '0;
        readback.trig_mode   = {30'd0, regs.trig_mode[1:0]};
        readback.capture_len = {16'd0, regs.capture_len[15:0]};
        readback.ctrl        = {30'd0, regs.ctrl[1:0]};
        readback.status      = {13'd0, state_q == CAPTURE, state_q == ARMED, done_q, ww_q[15:0]};
    end

    assign IPIF_IP2Bus_Error  = 1'b0;
    assign bram_CLK           = clk;
    assign bram_RST           = ~aresetn;
    assign data_stream_TREADY = aresetn;

    assign accept    = data_stream_TVALID & data_stream_TREADY;
    assign arm_edge  = regs.ctrl[0] & ~arm_prev;
    assign abort     = regs.ctrl[1];
    assign trigger   = (mode_q == TRIG_ORBIT) ? orbit_sync_r : 1'b1;
    assign last_word = (17'(widx_q) == len_q - 17'd1);
    assign arm_start = arm_edge && (state_q == IDLE || state_q == DONE) && !abort;

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE:    if (arm_edge) state_d = ARMED;
            ARMED:   if (trigger) begin
                         state_d = CAPTURE;
                         wr_en   = accept;
                     end
            CAPTURE: wr_en = accept;
            DONE:    if (arm_edge) state_d = ARMED;
            default: state_d = IDLE;
        endcase
        if (wr_en && last_word && mode_q != TRIG_RING)
            state_d = DONE;
        // Abort beats every other request, including a same-cycle arm or write.
        if (abort) begin
            state_d = IDLE;
            wr_en   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Only control and output-register state is reset; the BRAM itself keeps its contents.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            orbit_sync_r <= 1'b0;
            arm_prev     <= 1'b0;
            mode_q       <= TRIG_IMMEDIATE;
            len_q        <= 17'(MEM_DEPTH);
            widx_q       <= '0;
            ww_q         <= '0;
            done_q       <= 1'b0;
            en_q         <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
        end else begin
            orbit_sync_r <= fc_orbitSync;
            arm_prev     <= regs.ctrl[0];
            en_q         <= wr_en;
            if (arm_start) begin
                mode_q <= effective_mode(regs.trig_mode[1:0]);
                len_q  <= effective_len(regs.capture_len[15:0], MEM_DEPTH);
                widx_q <= '0;
                ww_q   <= '0;
                done_q <= 1'b0;
            end
            if (wr_en) begin
                addr_q <= widx_q;
                din_q  <= data_stream_TDATA;
                widx_q <= last_word ? '0 : widx_q + 1'b1;
                // Ring mode keeps overwriting, so the count saturates at the length.
                if (ww_q != len_q)
                    ww_q <= ww_q + 17'd1;
                if (last_word && mode_q != TRIG_RING)
                    done_q <= 1'b1;
            end
        end
    end

    assign bram_EN   = en_q;
    assign bram_WE   = {4{en_q}};
    assign bram_ADDR = 32'({addr_q, 2'b00});
    assign bram_DIN  = din_q;

    logic unused_bits;
    assign unused_bits = &{1'b0, IPIF_Bus2IP_Addr, IPIF_Bus2IP_RNW, IPIF_Bus2IP_BE,
                           IPIF_Bus2IP_CS, regs.status, regs.ctrl[31:2],
                           regs.capture_len[31:16], regs.trig_mode[31:2], ww_q[16]};

endmodule
